// File: rtl/regfile_pkg.sv
// Shared register-file widths, write-queue depth and the write-request record.
// Every block that touches the register-file write port takes its widths from here.
package regfile_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int WQ_DEPTH = 4;

    // Queue entries are stored as {wa, wd}, matching this record's packed layout.
    typedef struct packed {
        logic [RF_AW-1:0] wa;
        logic [RF_DW-1:0] wd;
    } wr_req_t;

endpackage

// File: rtl/wq_fifo.sv
// Write queue: power-of-two FIFO with count-based full/empty and a combinational head.
// Also exposes a per-slot valid bit and tag (top bits of each entry) for hazard tracking.
module wq_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 37,
    parameter int TW    = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push_i,
    input  logic [W-1:0]                  wdata_i,
    input  logic                          pop_i,
    output logic [W-1:0]                  head_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [DEPTH-1:0]              ent_valid_o,
    output logic [DEPTH-1:0][TW-1:0]      ent_tag_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s;

    // Next-state for pointers and occupancy; pushes at full and pops at empty are ignored.
    always_comb begin
        do_push_s = push_i && (count_q != CW'(DEPTH));
        do_pop_s  = pop_i && (count_q != {CW{1'b0}});
        wr_ptr_d  = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = do_pop_s  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; validity lives entirely in the pointers and count, so no reset here.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Slot i is occupied when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] offs_s;
        offs_s = {PW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            offs_s         = PW'(i) - rd_ptr_q;
            ent_valid_o[i] = (CW'(offs_s) < count_q);
            ent_tag_o[i]   = mem_q[i][W-1 -: TW];
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/regfile_writer.sv
// Merges load and ALU write-back requests into one queued register-file write port.
// Loads win arbitration; writes to r0 are acknowledged but dropped.
module regfile_writer
    import regfile_pkg::*;
#(
    parameter int DEPTH = WQ_DEPTH,
    parameter int AW    = RF_AW,
    parameter int DW    = RF_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_wa,
    input  logic [DW-1:0]          mem_wd,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [AW-1:0]          alu_wa,
    input  logic [DW-1:0]          alu_wd,
    input  logic                   wr_stall,
    output logic                   RWE,
    output logic [AW-1:0]          WA,
    output logic [DW-1:0]          WD,
    output logic [(2**AW)-1:0]     busy_mask,
    output logic [$clog2(DEPTH):0] count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = AW + DW;

    logic [CW-1:0]             count_s;
    logic [EW-1:0]             head_s;
    logic [DEPTH-1:0]          ent_valid_s;
    logic [DEPTH-1:0][AW-1:0]  ent_wa_s;
    logic                      not_full_s;
    logic                      acc_mem_s, acc_alu_s;
    logic                      push_s, pop_s;
    logic [AW-1:0]             sel_wa_s;
    logic [DW-1:0]             sel_wd_s;
    logic [(2**AW)-1:0]        busy_s;
    logic                      rwe_q;
    logic [AW-1:0]             wa_q;
    logic [DW-1:0]             wd_q;

    // Fixed-priority arbitration and r0 filtering; nothing bypasses the queue.
    always_comb begin
        not_full_s = (count_s < CW'(DEPTH));
        mem_ready  = not_full_s;
        alu_ready  = not_full_s && !mem_valid;
        acc_mem_s  = mem_valid && not_full_s;
        acc_alu_s  = alu_valid && not_full_s && !mem_valid;
        if (acc_mem_s) begin
            sel_wa_s = mem_wa;
            sel_wd_s = mem_wd;
        end else begin
            sel_wa_s = alu_wa;
            sel_wd_s = alu_wd;
        end
        push_s = (acc_mem_s || acc_alu_s) && (sel_wa_s != {AW{1'b0}});
        pop_s  = (count_s != {CW{1'b0}}) && !wr_stall;
    end

    wq_fifo #(
        .DEPTH (DEPTH),
        .W     (EW),
        .TW    (AW)
    ) u_wq (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .wdata_i     ({sel_wa_s, sel_wd_s}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (count_s),
        .ent_valid_o (ent_valid_s),
        .ent_tag_o   (ent_wa_s)
    );

    // Register-file write port; address/data hold when nothing retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rwe_q <= 1'b0;
            wa_q  <= {AW{1'b0}};
            wd_q  <= {DW{1'b0}};
        end else begin
            rwe_q <= pop_s;
            if (pop_s) begin
                wa_q <= head_s[EW-1 -: AW];
                wd_q <= head_s[DW-1:0];
            end else begin
                wa_q <= wa_q;
                wd_q <= wd_q;
            end
        end
    end

    // Pending-write scoreboard: every queued destination plus the one on the write port.
    always_comb begin
        busy_s = {(2**AW){1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            busy_s[ent_wa_s[i]] = busy_s[ent_wa_s[i]] | ent_valid_s[i];
        end
        busy_s[wa_q] = busy_s[wa_q] | rwe_q;
        busy_s[0]    = 1'b0;
    end

    assign busy_mask = busy_s;
    assign count     = count_s;
    assign RWE       = rwe_q;
    assign WA        = wa_q;
    assign WD        = wd_q;

endmodule

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: table vectors, hand sequences and a random soak,
// all checked against a queue-based scoreboard of pending writes.
module tb_regfile_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid, wr_stall;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_wa, alu_wa, WA;
    logic [31:0] mem_wd, alu_wd, WD;
    logic        RWE;
    logic [31:0] busy_mask;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    ent_t        mq[$];
    logic        m_rwe;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    typedef struct {
        logic        mv;
        logic [4:0]  mwa;
        logic [31:0] mwd;
        logic        av;
        logic [4:0]  awa;
        logic [31:0] awd;
        logic        st;
        logic        e_rwe;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        int          e_cnt;
    } vec_t;

    vec_t tbl[14];

    regfile_writer #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .wr_stall  (wr_stall),
        .RWE       (RWE),
        .WA        (WA),
        .WD        (WD),
        .busy_mask (busy_mask),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = 32'd0;
        foreach (mq[i]) b[mq[i].wa] = 1'b1;
        if (m_rwe) b[m_wa] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // One clock of stimulus, starting and ending at a falling edge.
    task automatic step(input logic mv, input logic [4:0] mwa, input logic [31:0] mwd,
                        input logic av, input logic [4:0] awa, input logic [31:0] awd,
                        input logic st, output logic acc);
        logic acc_m, acc_a, do_pop;
        ent_t e;
        mem_valid = mv; mem_wa = mwa; mem_wd = mwd;
        alu_valid = av; alu_wa = awa; alu_wd = awd;
        wr_stall  = st;
        #1;
        chk("mem_ready", 64'(mem_ready), 64'(mq.size() < DEPTH));
        chk("alu_ready", 64'(alu_ready), 64'((mq.size() < DEPTH) && !mv));
        acc_m  = mv && (mq.size() < DEPTH);
        acc_a  = av && (mq.size() < DEPTH) && !mv;
        do_pop = (mq.size() > 0) && !st;
        @(posedge clk);
        if (do_pop) begin
            e = mq.pop_front();
            m_rwe = 1'b1; m_wa = e.wa; m_wd = e.wd;
        end else begin
            m_rwe = 1'b0;
        end
        if (acc_m && mwa != 5'd0) mq.push_back('{mwa, mwd});
        else if (acc_a && awa != 5'd0) mq.push_back('{awa, awd});
        acc = acc_m || acc_a;
        @(negedge clk);
        chk("RWE", 64'(RWE), 64'(m_rwe));
        chk("WA", 64'(WA), 64'(m_wa));
        chk("WD", 64'(WD), 64'(m_wd));
        chk("count", 64'(count), 64'(mq.size()));
        chk("busy_mask", 64'(busy_mask), 64'(model_busy()));
    endtask

    task automatic idle(input logic st);
        logic a;
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, st, a);
    endtask

    initial begin
        logic acc;
        rst_n = 1'b0;
        mem_valid = 1'b0; mem_wa = 5'd0; mem_wd = 32'd0;
        alu_valid = 1'b0; alu_wa = 5'd0; alu_wd = 32'd0;
        wr_stall = 1'b0;
        mq.delete(); m_rwe = 1'b0; m_wa = 5'd0; m_wd = 32'd0;

        // Reset values
        #12;
        chk("rst RWE", 64'(RWE), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst WA", 64'(WA), 64'd0);
        chk("rst WD", 64'(WD), 64'd0);
        chk("rst busy", 64'(busy_mask), 64'd0);
        chk("rst mem_ready", 64'(mem_ready), 64'd1);
        chk("rst alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // Single load, arbitration, r0 drop, duplicate address
        tbl[0]  = '{1'b1, 5'd5, 32'd9,  1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd0, 32'd0,  1};
        tbl[1]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 5'd5, 32'd9,  0};
        tbl[2]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd5, 32'd9,  0};
        tbl[3]  = '{1'b1, 5'd2, 32'd20, 1'b1, 5'd7, 32'd70, 1'b0, 1'b0, 5'd5, 32'd9,  1};
        tbl[4]  = '{1'b1, 5'd3, 32'd30, 1'b1, 5'd7, 32'd70, 1'b0, 1'b1, 5'd2, 32'd20, 1};
        tbl[5]  = '{1'b0, 5'd0, 32'd0,  1'b1, 5'd7, 32'd70, 1'b0, 1'b1, 5'd3, 32'd30, 1};
        tbl[6]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 5'd7, 32'd70, 0};
        tbl[7]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd7, 32'd70, 0};
        tbl[8]  = '{1'b0, 5'd0, 32'd0,  1'b1, 5'd0, 32'hDEAD, 1'b0, 1'b0, 5'd7, 32'd70, 0};
        tbl[9]  = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd7, 32'd70, 0};
        tbl[10] = '{1'b0, 5'd0, 32'd0,  1'b1, 5'd3, 32'd11, 1'b0, 1'b0, 5'd7, 32'd70, 1};
        tbl[11] = '{1'b0, 5'd0, 32'd0,  1'b1, 5'd3, 32'd17, 1'b0, 1'b1, 5'd3, 32'd11, 1};
        tbl[12] = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b1, 5'd3, 32'd17, 0};
        tbl[13] = '{1'b0, 5'd0, 32'd0,  1'b0, 5'd0, 32'd0,  1'b0, 1'b0, 5'd3, 32'd17, 0};
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].mv, tbl[i].mwa, tbl[i].mwd, tbl[i].av, tbl[i].awa, tbl[i].awd,
                 tbl[i].st, acc);
            chk($sformatf("vec%0d RWE", i), 64'(RWE), 64'(tbl[i].e_rwe));
            chk($sformatf("vec%0d WA", i), 64'(WA), 64'(tbl[i].e_wa));
            chk($sformatf("vec%0d WD", i), 64'(WD), 64'(tbl[i].e_wd));
            chk($sformatf("vec%0d count", i), 64'(count), 64'(tbl[i].e_cnt));
            if (i == 0 || i == 1) chk("busy5", 64'(busy_mask[5]), 64'd1);
            if (i == 2) chk("busy5 clear", 64'(busy_mask[5]), 64'd0);
            if (i == 8) chk("r0 acc", 64'(acc), 64'd1);
            if (i == 11) chk("busy3 dup", 64'(busy_mask[3]), 64'd1);
        end

        // Fill under stall, then drain back-to-back
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 5'd0, 32'd0, 1'b1, 5'(k), 32'(100 + k), 1'b1, acc);
            chk("stall fill acc", 64'(acc), 64'd1);
        end
        chk("full count", 64'(count), 64'd4);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd105, 1'b1, acc);
        chk("full reject", 64'(acc), 64'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd105, 1'b0, acc);
        chk("full reject2", 64'(acc), 64'd0);
        chk("drain wa1", 64'(WA), 64'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'd105, 1'b0, acc);
        chk("accept wa5", 64'(acc), 64'd1);
        chk("drain wa2", 64'(WA), 64'd2);
        for (int k = 3; k <= 5; k++) begin
            idle(1'b0);
            chk("drain seq", 64'(WA), 64'(k));
        end
        idle(1'b0);

        // Mid-operation reset with stall toggling
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9,  32'd90,  1'b1, acc);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'd100, 1'b1, acc);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd11, 32'd110, 1'b0, acc);
        step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'd120, 1'b1, acc);
        chk("pre-rst count", 64'(count), 64'd3);
        alu_valid = 1'b0;
        mem_valid = 1'b1;
        wr_stall  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid rst RWE", 64'(RWE), 64'd0);
        chk("mid rst count", 64'(count), 64'd0);
        chk("mid rst busy", 64'(busy_mask), 64'd0);
        chk("mid rst mem_ready", 64'(mem_ready), 64'd1);
        chk("mid rst alu_ready", 64'(alu_ready), 64'd0);
        mq.delete(); m_rwe = 1'b0; m_wa = 5'd0; m_wd = 32'd0;
        @(negedge clk);
        mem_valid = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) idle(1'b0);
        step(1'b1, 5'd13, 32'd130, 1'b0, 5'd0, 32'd0, 1'b0, acc);
        idle(1'b0);
        chk("post-rst write", 64'(WA), 64'd13);
        idle(1'b0);

        // Random soak against the scoreboard
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                 1'($urandom_range(0, 3) == 0), acc);
        end
        for (int n = 0; n < 6; n++) idle(1'b0);
        chk("final count", 64'(count), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writer.md
REGFILE_WRITER -- requirements
Module: regfile_writer

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; rst_n  input  1  asynchronous active-low reset.
REQ-002 The block SHALL have these parameters: DEPTH, 4, number of write-queue entries (power of two, 2..8); AW, 5, register address width; DW, 32, register data width.
REQ-003 The block SHALL have these ports:
- mem_valid  input  1  load-result write request
- mem_ready  output  1  load request accepted this edge when high with mem_valid
- mem_wa  input  AW  load destination register
- mem_wd  input  DW  load write data
- alu_valid  input  1  ALU-result write request
- alu_ready  output  1  ALU request accepted this edge when high with alu_valid
- alu_wa  input  AW  ALU destination register
- alu_wd  input  DW  ALU write data
- wr_stall  input  1  register-file write port unavailable this cycle
- RWE  output  1  register-file write enable, registered
- WA  output  AW  register-file write address, registered
- WD  output  DW  register-file write data, registered
- busy_mask  output  2**AW  bit i high while a write to register i is queued or on RWE/WA/WD
- count  output  clog2(DEPTH)+1  number of occupied queue entries

Function
REQ-004 mem_ready SHALL equal (count < DEPTH), combinationally, with no dependency on mem_valid.
REQ-005 alu_ready SHALL equal (count < DEPTH) && !mem_valid, so the load source has fixed priority.
REQ-006 At most one request SHALL be accepted per edge, and there SHALL be no same-cycle pass-through when the queue is full.
REQ-007 An accepted request with WA == 0 SHALL be consumed: the handshake completes, but no entry is enqueued and no RWE is produced.
REQ-008 The queue SHALL be first-in first-out; entries with duplicate WA are kept in order, so the last write wins in the register file.
REQ-009 Drain: on each edge where count > 0 and wr_stall = 0, the head entry SHALL be popped into WA/WD with RWE = 1; otherwise RWE SHALL be 0 on that edge, and WA/WD hold their previous values.
REQ-010 Latency: a request accepted at edge N into an empty queue, with wr_stall low, SHALL drive RWE = 1 during the cycle after edge N+1.
REQ-011 Sustained throughput SHALL be one write per cycle when there is no stall.
REQ-012 A simultaneous push and pop SHALL leave count unchanged.
REQ-013 A push at count == DEPTH-1 together with a pop SHALL leave count at DEPTH-1.
REQ-014 Pointers SHALL wrap modulo DEPTH; full and empty SHALL be derived from count, not from pointer equality.
REQ-015 busy_mask SHALL be the combinational OR of one-hot(WA) over all valid queue entries, plus one-hot(WA) when RWE = 1.
REQ-016 busy_mask bit 0 SHALL always be 0.
REQ-017 When wr_stall is asserted mid-drain, the queue SHALL hold, no entry SHALL be lost or duplicated, and draining SHALL resume on the first edge with wr_stall low.

Reset
REQ-018 On rst_n low, asynchronously: count = 0, pointers = 0, RWE = 0, WA = 0, WD = 0, busy_mask = 0, mem_ready = 1, alu_ready = !mem_valid.
REQ-019 A reset asserted mid-operation SHALL discard all queued entries with no partial write; the first write after reset deasserts is the first request accepted after it.
REQ-020 Queue storage SHALL need no reset; only the valid/count state is reset.

Structure
REQ-021 AW, DW, DEPTH defaults and a wr_req record (wa, wd) SHALL live in the shared package regfile_pkg, with the reg_file read/write port widths taken from the same package.
REQ-022 The queue SHALL be one sub-module, wq_fifo (push/pop/count/head, combinational head, registered state).
REQ-023 Arbitration, r0 filtering, the output register and busy_mask SHALL live in regfile_writer.

Verification
REQ-024 Reset, then mem_valid=1, mem_wa=5, mem_wd=9 for one cycle -> RWE=1, WA=5, WD=9 in the cycle after the second edge; busy_mask[5]=1 from the accept edge until RWE falls.
REQ-025 mem_valid and alu_valid both high for 2 cycles (mem wa=2/3, alu wa=7) -> alu_ready=0 for both cycles; writes to 2 then 3; alu write to 7 follows after mem_valid drops.
REQ-026 wr_stall=1 and 5 ALU pushes (wa=1..5) -> count reaches 4, alu_ready=0 at count 4; release the stall -> RWE for wa 1,2,3,4 on consecutive cycles, then 5 once accepted.
REQ-027 Push wa=0, wd=32'hDEAD -> ready handshake completes, count stays 0, RWE stays 0, busy_mask[0]=0.
REQ-028 Two pushes to wa=3 (wd=11, then 17) -> two RWE cycles in order, busy_mask[3] stays 1 until the second write retires.
REQ-029 With 3 entries queued and wr_stall toggling, pull rst_n low -> RWE=0 and count=0 immediately; after release, no stale writes appear.
